pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
//
// PURPOSE
// Consumer end of the PLL reset/locked handshake. Runs on the free-running
// 74.25 MHz reference clock, not on a PLL output, so it stays alive while the
// PLL is unlocked. Drives the PLL reset and waits for a debounced, stable lock.
// Only then does it release the core reset. On loss of lock it re-resets the
// PLL and reports timeouts and lock-loss events.
//
// PARAMETERS
// PLL_RST_CYCLES   16       cycles pll_rst is held high per reset pulse (>=2)
// STABLE_CYCLES    1024     consecutive synchronized-locked cycles before release (>=2)
// LOCK_TIMEOUT     1048576  cycles in WAIT_LOCK before a retry (>=2)
// CNT_WIDTH        8        width of the lock_lost_count / retry_count saturating counters
//
// PORTS
// clk_74a          in   1          free-running reference clock; all logic on its rising edge
// reset_n          in   1          asynchronous, active-low reset
// pll_locked       in   1          PLL locked flag; asynchronous to clk_74a
// pll_rst          out  1          PLL reset request, active high
// core_reset_n     out  1          core reset, active low; high only while state == RUN
// pll_ready        out  1          high while state == RUN (same timing as core_reset_n)
// timeout_err      out  1          sticky: at least one lock timeout since reset
// lock_lost_count  out  CNT_WIDTH  number of RUN->lock-lost events, saturating
// retry_count      out  CNT_WIDTH  number of lock timeouts, saturating
//
// BEHAVIOUR
// - Reset (reset_n low, async, takes effect mid-operation):
//   state=RESET_PLL, pll_rst=1, core_reset_n=0, pll_ready=0, timeout_err=0,
//   both counters 0, all timers 0, synchronizer flops 0.
// - pll_locked passes through a 2-FF synchronizer to locked_s (2-cycle latency).
//   Only locked_s is used. Pulses shorter than one clk_74a period may be missed.
// - All outputs are registered. Each takes its new value in the cycle after the
//   state transition that causes it.
// - RESET_PLL: pll_rst=1, core_reset_n=0.
//   Timer counts 0..PLL_RST_CYCLES-1, then moves to WAIT_LOCK with the timer cleared.
// - WAIT_LOCK: pll_rst=0.
//   - locked_s=1: go to STABILIZE with the stable counter at 0.
//   - Else, timer == LOCK_TIMEOUT-1: set timeout_err=1, increment retry_count
//     (saturating), go to RESET_PLL.
// - STABILIZE: the stable counter increments each cycle locked_s=1.
//   - locked_s=0: go to WAIT_LOCK. Timeout timer restarts from 0; no counter changes.
//   - Counter reaches STABLE_CYCLES-1 with locked_s=1: go to RUN. core_reset_n and
//     pll_ready rise on the next edge, i.e. STABLE_CYCLES cycles after the first
//     locked_s=1 in STABILIZE.
// - RUN: core_reset_n=1, pll_ready=1, pll_rst=0.
//   - locked_s=0: core_reset_n=0 and pll_ready=0 on the next edge, lock_lost_count
//     increments (saturating), go to RESET_PLL.
// - Saturation: at 2**CNT_WIDTH-1 a counter holds its value; no wrap to 0.
// - timeout_err is cleared only by reset_n.
// - A loss of lock and a timer expiry in the same cycle cannot conflict; each state
//   evaluates exactly one condition. In STABILIZE, locked_s=0 takes priority over
//   the terminal count.
// - Unused/illegal state encodings go to RESET_PLL.
//
// TESTING (bench parameters: PLL_RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32, CNT_WIDTH=8)
// 1. Release reset_n; pll_locked=1 from cycle 10.
//    -> pll_rst high for cycles 0-3; core_reset_n rises exactly 2 (sync) + 8 cycles
//       after pll_locked is sampled in WAIT_LOCK; counters 0; timeout_err=0.
// 2. pll_locked held 0.
//    -> pll_rst re-pulses (4 cycles) every 36 cycles; timeout_err=1 after the first
//       timeout; retry_count=3 after 3 timeouts; core_reset_n stays 0.
// 3. In STABILIZE, drop pll_locked for 1 cycle after 5 locked cycles.
//    -> return to WAIT_LOCK; core_reset_n rises only after a fresh 8 consecutive
//       locked cycles; lock_lost_count=0.
// 4. In RUN, drop pll_locked.
//    -> core_reset_n falls 3 cycles later (2 sync + 1); lock_lost_count=1;
//       pll_rst=1 for 4 cycles; relock -> RUN again.
// 5. Force 300 RUN lock-loss events. -> lock_lost_count saturates at 255.
// 6. Assert reset_n mid-STABILIZE and mid-RUN.
//    -> all outputs return to reset values asynchronously; counters and timeout_err
//       cleared; sequence restarts at RESET_PLL.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Sequences the PLL reset/locked handshake from the free-running reference
// clock. The block pulses the PLL reset, then waits for a synchronized lock
// that stays stable. Only after that does it release the core reset. If lock
// is lost, or lock is not achieved in time, the PLL is reset again. Both kinds
// of event are counted.
//
// Ports
//   clk_74a          in   free-running reference clock (rising edge)
//   reset_n          in   asynchronous active-low reset
//   pll_locked       in   PLL lock flag, asynchronous to clk_74a
//   pll_rst          out  PLL reset request, active high
//   core_reset_n     out  core reset, active low, high only in RUN
//   pll_ready        out  high only in RUN
//   timeout_err      out  sticky flag, set by any lock timeout
//   lock_lost_count  out  saturating count of lock losses while in RUN
//   retry_count      out  saturating count of lock timeouts
//
// state     | meaning
// ----------+--------------------------------------------------------
// RESET_PLL | pll_rst held high for PLL_RST_CYCLES cycles
// WAIT_LOCK | waiting for locked_s, bounded by LOCK_TIMEOUT cycles
// STABILIZE | counting STABLE_CYCLES consecutive locked_s cycles
// RUN       | core released; any locked_s drop re-resets the PLL

module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 1048576,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk_74a,
  input  logic                 reset_n,
  input  logic                 pll_locked,
  output logic                 pll_rst,
  output logic                 core_reset_n,
  output logic                 pll_ready,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] lock_lost_count,
  output logic [CNT_WIDTH-1:0] retry_count
);

  // One timer serves both RESET_PLL and WAIT_LOCK, so it is sized for the longer of the two.
  localparam int TMR_MAX = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam int STB_W   = $clog2(STABLE_CYCLES);

  localparam logic [TMR_W-1:0]     RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]     TMO_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0]     STB_LAST = STB_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [STB_W-1:0] stable_cnt;
  logic             locked_meta;
  logic             locked_s;

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= pll_locked;
      locked_s    <= locked_meta;
    end
  end

  // The outputs are assigned together with the state change that causes them.
  // Each output is therefore a registered copy of the state it belongs to.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state           <= RESET_PLL;
      timer           <= '0;
      stable_cnt      <= '0;
      pll_rst         <= 1'b1;
      core_reset_n    <= 1'b0;
      pll_ready       <= 1'b0;
      timeout_err     <= 1'b0;
      lock_lost_count <= '0;
      retry_count     <= '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (timer == RST_LAST) begin
            state   <= WAIT_LOCK;
            timer   <= '0;
            pll_rst <= 1'b0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (locked_s) begin
            state      <= STABILIZE;
            stable_cnt <= '0;
          end else if (timer == TMO_LAST) begin
            state       <= RESET_PLL;
            timer       <= '0;
            pll_rst     <= 1'b1;
            timeout_err <= 1'b1;
            if (retry_count != CNT_MAX) retry_count <= retry_count + CNT_WIDTH'(1);
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        STABILIZE: begin
          // A lock drop takes priority over the terminal count.
          if (!locked_s) begin
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (stable_cnt == STB_LAST) begin
            state        <= RUN;
            core_reset_n <= 1'b1;
            pll_ready    <= 1'b1;
          end else begin
            stable_cnt <= stable_cnt + STB_W'(1);
          end
        end

        RUN: begin
          if (!locked_s) begin
            state        <= RESET_PLL;
            timer        <= '0;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            pll_ready    <= 1'b0;
            if (lock_lost_count != CNT_MAX) lock_lost_count <= lock_lost_count + CNT_WIDTH'(1);
          end
        end

        default: begin
          state        <= RESET_PLL;
          timer        <= '0;
          pll_rst      <= 1'b1;
          core_reset_n <= 1'b0;
          pll_ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//
// Bench for pll_lock_supervisor with PLL_RST_CYCLES=4, STABLE_CYCLES=8,
// LOCK_TIMEOUT=32 and CNT_WIDTH=8. The expected latencies and counts are
// pushed onto a queue when the stimulus is driven. Each one is popped and
// compared once the DUT shows the matching event.

module tb_pll_lock_supervisor;

  logic       clk_74a;
  logic       reset_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       core_reset_n;
  logic       pll_ready;
  logic       timeout_err;
  logic [7:0] lock_lost_count;
  logic [7:0] retry_count;
  logic [19:0] outs;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    string name;
    int    value;
  } exp_t;
  exp_t sb[$];

  localparam logic [19:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4),
    .STABLE_CYCLES (8),
    .LOCK_TIMEOUT  (32),
    .CNT_WIDTH     (8)
  ) dut (
    .clk_74a        (clk_74a),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .pll_rst        (pll_rst),
    .core_reset_n   (core_reset_n),
    .pll_ready      (pll_ready),
    .timeout_err    (timeout_err),
    .lock_lost_count(lock_lost_count),
    .retry_count    (retry_count)
  );

  assign outs = {pll_rst, core_reset_n, pll_ready, timeout_err, lock_lost_count, retry_count};

  initial clk_74a = 1'b0;
  always #5 clk_74a = ~clk_74a;

  task automatic tick();
    @(posedge clk_74a);
    #1;
  endtask

  function automatic logic sig_of(input int sel);
    return (sel == 0) ? core_reset_n : pll_rst;
  endfunction

  // sel 0 = core_reset_n, 1 = pll_rst. Returns the number of edges until the
  // signal reads val. Returns -1 if the bound expires first.
  task automatic ticks_until(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (sig_of(sel) !== val) begin
      if (n >= limit) begin
        n = -1;
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic hold_reset();
    reset_n = 1'b0;
    repeat (2) tick();
  endtask

  task automatic do_release();
    @(negedge clk_74a);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    pll_locked = 1'b0;
    reset_n    = 1'b0;
    repeat (3) tick();
    n_total++;
    if (outs !== RESET_VEC) $display("FAIL reset_outputs: got %h expected %h", outs, RESET_VEC);
    else n_pass++;
  endtask

  task automatic test_startup();
    int n;
    exp_t e;
    sb.push_back('{"startup_rst_pulse", 4});
    do_release();
    ticks_until(1, 1'b0, 50, n);
    e = sb.pop_front();
    n_total++;
    if (n !== e.value) $display("FAIL %s: got %0d expected %0d", e.name, n, e.value);
    else n_pass++;
    repeat (6) tick();
    sb.push_back('{"startup_lock_to_core", 11});
    pll_locked = 1'b1;
    ticks_until(0, 1'b1, 100, n);
    e = sb.pop_front();
    n_total++;
    if (n !== e.value) $display("FAIL %s: got %0d expected %0d", e.name, n, e.value);
    else n_pass++;
    n_total++;
    if (outs !== {1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0})
      $display("FAIL startup_run_outputs: got %h expected %h", outs, {1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0});
    else n_pass++;
  endtask

  task automatic test_lock_loss();
    int n;
    exp_t e;
    sb.push_back('{"loss_core_fall", 3});
    sb.push_back('{"loss_rerst_len", 4});
    sb.push_back('{"loss_count", 1});
    sb.push_back('{"loss_relock", 11});
    pll_locked = 1'b0;
    ticks_until(0, 1'b0, 20, n);
    e = sb.pop_front();
    n_total++;
    if (n !== e.value) $display("FAIL %s: got %0d expected %0d", e.name, n, e.value);
    else n_pass++;
    ticks_until(1, 1'b0, 20, n);
    e = sb.pop_front();
    n_total++;
    if (n !== e.value) $display("FAIL %s: got %0d expected %0d", e.name, n, e.value);
    else n_pass++;
    e = sb.pop_front();
    n_total++;
    if (int'(lock_lost_count) !== e.value)
      $display("FAIL %s: got %0d expected %0d", e.name, lock_lost_count, e.value);
    else n_pass++;
    pll_locked = 1'b1;
    ticks_until(0, 1'b1, 100, n);
    e = sb.pop_front();
    n_total++;
    if (n !== e.value) $display("FAIL %s: got %0d expected %0d", e.name, n, e.value);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n;
    exp_t e;
    logic [19:0] want;
    hold_reset();
    pll_locked = 1'b0;
    do_release();
    ticks_until(1, 1'b0, 50, n);
    n_total++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_err_early: got %b expected 0", timeout_err);
    else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      sb.push_back('{"timeout_wait_len", 32});
      sb.push_back('{"timeout_rerst_len", 4});
      ticks_until(1, 1'b1, 100, n);
      e = sb.pop_front();
      n_total++;
      if (n !== e.value) $display("FAIL %s[%0d]: got %0d expected %0d", e.name, k, n, e.value);
      else n_pass++;
      want = {1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'(k)};
      n_total++;
      if (outs !== want) $display("FAIL timeout_status[%0d]: got %h expected %h", k, outs, want);
      else n_pass++;
      ticks_until(1, 1'b0, 50, n);
      e = sb.pop_front();
      n_total++;
      if (n !== e.value) $display("FAIL %s[%0d]: got %0d expected %0d", e.name, k, n, e.value);
      else n_pass++;
    end
  endtask

  task automatic test_stabilize_glitch();
    int n;
    exp_t e;
    hold_reset();
    pll_locked = 1'b0;
    do_release();
    ticks_until(1, 1'b0, 50, n);
    sb.push_back('{"glitch_lock_to_core", 18});
    pll_locked = 1'b1;
    repeat (6) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    ticks_until(0, 1'b1, 100, n);
    if (n >= 0) n += 7;
    e = sb.pop_front();
    n_total++;
    if (n !== e.value) $display("FAIL %s: got %0d expected %0d", e.name, n, e.value);
    else n_pass++;
    n_total++;
    if (outs !== {1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0})
      $display("FAIL glitch_outputs: got %h expected %h", outs, {1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0});
    else n_pass++;
  endtask

  task automatic test_saturation();
    int n1, n2, n3;
    int bad_timing;
    exp_t e;
    bad_timing = 0;
    hold_reset();
    pll_locked = 1'b1;
    do_release();
    ticks_until(0, 1'b1, 100, n1);
    for (int i = 1; i <= 300; i++) begin
      sb.push_back('{"lost_count_sat", (i > 255) ? 255 : i});
      pll_locked = 1'b0;
      ticks_until(0, 1'b0, 20, n1);
      ticks_until(1, 1'b0, 20, n2);
      pll_locked = 1'b1;
      ticks_until(0, 1'b1, 100, n3);
      if (n1 != 3 || n2 != 4 || n3 != 11) bad_timing++;
      e = sb.pop_front();
      n_total++;
      if (int'(lock_lost_count) !== e.value)
        $display("FAIL %s[%0d]: got %0d expected %0d", e.name, i, lock_lost_count, e.value);
      else n_pass++;
    end
    n_total++;
    if (bad_timing !== 0) $display("FAIL sat_loop_timing: got %0d bad events expected 0", bad_timing);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int n;
    exp_t e;
    hold_reset();
    pll_locked = 1'b0;
    do_release();
    ticks_until(1, 1'b0, 50, n);
    ticks_until(1, 1'b1, 100, n);
    ticks_until(1, 1'b0, 50, n);
    pll_locked = 1'b1;
    repeat (5) tick();
    n_total++;
    if (outs !== {1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1})
      $display("FAIL pre_stab_reset: got %h expected %h", outs, {1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1});
    else n_pass++;
    #3 reset_n = 1'b0;
    #1;
    n_total++;
    if (outs !== RESET_VEC) $display("FAIL async_reset_stab: got %h expected %h", outs, RESET_VEC);
    else n_pass++;
    sb.push_back('{"restart_locked_to_core", 13});
    do_release();
    ticks_until(0, 1'b1, 100, n);
    e = sb.pop_front();
    n_total++;
    if (n !== e.value) $display("FAIL %s: got %0d expected %0d", e.name, n, e.value);
    else n_pass++;
    pll_locked = 1'b0;
    ticks_until(0, 1'b0, 20, n);
    ticks_until(1, 1'b0, 20, n);
    pll_locked = 1'b1;
    ticks_until(0, 1'b1, 100, n);
    n_total++;
    if (outs !== {1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0})
      $display("FAIL pre_run_reset: got %h expected %h", outs, {1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0});
    else n_pass++;
    #3 reset_n = 1'b0;
    #1;
    n_total++;
    if (outs !== RESET_VEC) $display("FAIL async_reset_run: got %h expected %h", outs, RESET_VEC);
    else n_pass++;
    pll_locked = 1'b0;
    sb.push_back('{"restart_rst_pulse", 4});
    do_release();
    ticks_until(1, 1'b0, 50, n);
    e = sb.pop_front();
    n_total++;
    if (n !== e.value) $display("FAIL %s: got %0d expected %0d", e.name, n, e.value);
    else n_pass++;
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    test_reset();
    test_startup();
    test_lock_loss();
    test_timeout();
    test_stabilize_glitch();
    test_saturation();
    test_async_reset();
    n_total++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
